// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic sequencer slice.
// Holds the sequencer state encoding, default array geometry and a lane-slice helper.
package tpu_pkg;

    localparam int SEQ_N      = 4;
    localparam int SEQ_DATA_W = 8;
    localparam int SEQ_K_W    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    function automatic logic [SEQ_DATA_W-1:0] lane(
        input logic [SEQ_N*SEQ_DATA_W-1:0] vec,
        input int                          i
    );
        return vec[i*SEQ_DATA_W +: SEQ_DATA_W];
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// skew_line: DEPTH-stage data+valid delay line for one array-edge lane.
// The output is forced to zero whenever the valid bit at the tap is low.
module skew_line #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              vin,
    output logic [DATA_W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, clr};
            assign dout      = vin ? din : '0;
        end else begin : g_line
            logic [DATA_W-1:0] d_q [DEPTH];
            logic [DEPTH-1:0]  v_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                    for (int s = 0; s < DEPTH; s++) d_q[s] <= '0;
                end else begin
                    // clr only drops valid bits; stale data is masked at the tap
                    if (clr) begin
                        v_q <= '0;
                    end else begin
                        v_q[0] <= vin;
                        for (int s = 1; s < DEPTH; s++) v_q[s] <= v_q[s-1];
                    end
                    d_q[0] <= din;
                    for (int s = 1; s < DEPTH; s++) d_q[s] <= d_q[s-1];
                end
            end

            assign dout = v_q[DEPTH-1] ? d_q[DEPTH-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary MAC array: operand reads, edge skew, clear/enable, done.
// Optional SYSTOLIC_SEQ_PERF_EN adds perf_cycles (accept through DONE, inclusive).
//
//  state | meaning
//  IDLE  | waiting for start; arrays held (arr_en=0)
//  CLEAR | one cycle of arr_clr to wipe PE sums
//  FEED  | K buffer reads, addr 0..K-1, array enabled
//  DRAIN | 2N-1 cycles letting the skewed wavefront reach PE(N-1,N-1)
//  DONE  | one-cycle done pulse, sums final and held
module systolic_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int N      = SEQ_N,
    parameter int DATA_W = SEQ_DATA_W,
    parameter int K_W    = SEQ_K_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                buf_rd_en,
    output logic [K_W-1:0]      buf_rd_addr,
    input  logic [N*DATA_W-1:0] a_vec,
    input  logic [N*DATA_W-1:0] b_vec,
    output logic [N*DATA_W-1:0] a_west,
    output logic [N*DATA_W-1:0] b_north,
    output logic                arr_clr,
    output logic                arr_en
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    localparam int DR_W = $clog2(2*N);

    seq_state_e      state;
    logic [K_W-1:0]  k_len_q;
    logic [DR_W-1:0] drain_cnt;
    logic            rd_valid;
    logic            kill;

    assign kill = abort && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            k_len_q     <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
            arr_clr     <= 1'b0;
            arr_en      <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            buf_rd_en <= 1'b0;
            arr_clr   <= 1'b0;
            arr_en    <= 1'b0;
        end else begin
            done    <= 1'b0;
            arr_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        k_len_q <= k_len;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                        arr_en  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (k_len_q == '0) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        arr_en <= 1'b0;
                    end else begin
                        state       <= FEED;
                        buf_rd_en   <= 1'b1;
                        buf_rd_addr <= '0;
                        arr_en      <= 1'b1;
                    end
                end
                FEED: begin
                    if (buf_rd_addr == k_len_q - 1'b1) begin
                        state     <= DRAIN;
                        buf_rd_en <= 1'b0;
                        drain_cnt <= DR_W'(2*N-2);
                    end else begin
                        buf_rd_addr <= buf_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        arr_en <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    arr_en <= 1'b0;
                end
            endcase
        end
    end

    // read data returns one cycle after the strobe; this bit marks it valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= buf_rd_en && !kill;
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_lane
            skew_line #(.DATA_W(DATA_W), .DEPTH(g)) u_a_skew (
                .clk  (clk),
                .rst  (rst),
                .clr  (kill),
                .din  (a_vec[g*DATA_W +: DATA_W]),
                .vin  (rd_valid),
                .dout (a_west[g*DATA_W +: DATA_W])
            );
            skew_line #(.DATA_W(DATA_W), .DEPTH(g)) u_b_skew (
                .clk  (clk),
                .rst  (rst),
                .clr  (kill),
                .din  (b_vec[g*DATA_W +: DATA_W]),
                .vin  (rd_valid),
                .dout (b_north[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else if (state == IDLE) begin
            perf_cnt <= start ? 32'd1 : 32'd0;
        end else if (kill) begin
            perf_cnt <= '0;
        end else if (state == DONE) begin
            perf_cycles <= perf_cnt + 32'd1;
        end else begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: operand buffer and PE grid are modelled here,
// every expectation is a hand-derived constant or a plain matrix-product reference.
module tb_systolic_seq_ctrl;
    import tpu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst, start, abort;
    logic [KW-1:0]   k_len;
    logic            busy, done, buf_rd_en, arr_clr, arr_en;
    logic [KW-1:0]   buf_rd_addr;
    logic [N*DW-1:0] a_vec, b_vec, a_west, b_north;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    systolic_seq_ctrl #(.N(N), .DATA_W(DW), .K_W(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .a_west      (a_west),
        .b_north     (b_north),
        .arr_clr     (arr_clr),
        .arr_en      (arr_en)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // operand buffers: one-cycle read latency, junk on the bus when not reading
    logic [7:0] amem [16][N];
    logic [7:0] bmem [16][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            a_vec[i*DW +: DW] <= buf_rd_en ? amem[buf_rd_addr[3:0]][i] : 8'hEE;
            b_vec[i*DW +: DW] <= buf_rd_en ? bmem[buf_rd_addr[3:0]][i] : 8'hEE;
        end
    end

    // output-stationary PE grid: A flows east, B flows south
    int         sums [N][N];
    logic [7:0] ar   [N][N];
    logic [7:0] br   [N][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [7:0] ai, bi;
                ai = (j == 0) ? lane(a_west, i) : ar[i][(j == 0) ? 0 : j-1];
                bi = (i == 0) ? lane(b_north, j) : br[(i == 0) ? 0 : i-1][j];
                if (arr_clr) begin
                    sums[i][j] <= 0;
                    ar[i][j]   <= 8'd0;
                    br[i][j]   <= 8'd0;
                end else if (arr_en) begin
                    sums[i][j] <= sums[i][j] + int'(ai) * int'(bi);
                    ar[i][j]   <= ai;
                    br[i][j]   <= bi;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // per-cycle trace of one job, index n = cycles after the accept cycle
    logic [N*DW-1:0] aw_log [64];
    logic [N*DW-1:0] bn_log [64];
    logic            busy_log [64];
    logic            done_log [64];
    logic            en_log   [64];
    logic            clr_log  [64];
    logic            rd_log   [64];
    logic [KW-1:0]   addr_log [64];

    task automatic log_cycle(input int n);
        aw_log[n]   = a_west;
        bn_log[n]   = b_north;
        busy_log[n] = busy;
        done_log[n] = done;
        en_log[n]   = arr_en;
        clr_log[n]  = arr_clr;
        rd_log[n]   = buf_rd_en;
        addr_log[n] = buf_rd_addr;
    endtask

    // lat = cycle index of done, -1 if done never came within the budget
    task automatic run_job(input int k, input bit hold, input int abort_at, output int lat);
        int n;
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            done_log[i] = 1'b0;
            en_log[i]   = 1'b0;
            clr_log[i]  = 1'b0;
            rd_log[i]   = 1'b0;
        end
        k_len = KW'(k);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        n = 1;
        log_cycle(n);
        while (n < 60) begin
            if (done) begin
                lat = n;
                break;
            end
            if (n == abort_at) abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            n++;
            log_cycle(n);
        end
    endtask

    int exp_c [N][N];

    task automatic fill_const(input int av, input int bv);
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < N; i++) begin
                amem[k][i] = 8'(av);
                bmem[k][i] = 8'(bv);
            end
    endtask

    task automatic set_exp_const(input int v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_c[i][j] = v;
    endtask

    task automatic compute_ref(input int k);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_c[i][j] = 0;
                for (int kk = 0; kk < k; kk++)
                    exp_c[i][j] += int'(amem[kk][i]) * int'(bmem[kk][j]);
            end
    endtask

    task automatic check_grid(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_pe%0d%0d", tag, i, j), sums[i][j], exp_c[i][j]);
    endtask

    function automatic int count_log(input int which, input int last);
        int c = 0;
        for (int n = 1; n <= last && n < 64; n++) begin
            case (which)
                0: c += int'(done_log[n]);
                1: c += int'(en_log[n]);
                default: c += int'(clr_log[n]);
            endcase
        end
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int idx;
`ifdef SYSTOLIC_SEQ_PERF_EN
        logic [31:0] perf_save;
`endif
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        fill_const(0, 0);
        repeat (3) @(negedge clk);

        chk("rst_busy",    busy,      0);
        chk("rst_done",    done,      0);
        chk("rst_rd_en",   buf_rd_en, 0);
        chk("rst_en",      arr_en,    0);
        chk("rst_clr",     arr_clr,   0);
        chk("rst_a_west",  a_west,    0);
        chk("rst_b_north", b_north,   0);
        rst = 1'b0;
        @(negedge clk);

        // job 1: K=3, all ones
        fill_const(1, 1);
        run_job(3, 1'b0, 0, lat);
        chk("k3_latency", lat, 12);
        chk("k3_clr_first", clr_log[1], 1);
        chk("k3_done_once", count_log(0, lat), 1);
        chk("k3_busy_in_done", busy, 1);
        set_exp_const(3);
        check_grid("k3");
        @(negedge clk);
        chk("k3_idle_busy", busy, 0);
        chk("k3_idle_done", done, 0);
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("k3_perf", perf_cycles, 13);
`endif

        // job 2: K=2, A=2, B=3; CLEAR must wipe the previous sums
        fill_const(2, 3);
        run_job(2, 1'b0, 0, lat);
        chk("k2_latency", lat, 11);
        set_exp_const(12);
        check_grid("k2");
        @(negedge clk);

        // K=0: CLEAR then DONE, array never enabled
        run_job(0, 1'b0, 0, lat);
        chk("k0_latency", lat, 2);
        chk("k0_en_count", count_log(1, lat), 0);
        set_exp_const(0);
        check_grid("k0");
        @(negedge clk);

        // start held high through a K=4 job
        fill_const(1, 1);
        run_job(4, 1'b1, 0, lat);
        chk("hold_latency", lat, 13);
        chk("hold_one_clear", count_log(2, lat), 1);
        idx = 0;
        for (int n = 1; n <= lat; n++) begin
            if (rd_log[n]) begin
                chk($sformatf("hold_addr%0d", idx), addr_log[n], idx);
                idx++;
            end
        end
        chk("hold_addr_count", idx, 4);
        @(negedge clk);
        chk("hold_idle_gap", busy, 0);
        @(negedge clk);
        chk("hold_reaccept", arr_clr, 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("hold_abort_idle", busy, 0);
        @(negedge clk);

        // abort on the second DRAIN cycle (n=6 for K=3)
`ifdef SYSTOLIC_SEQ_PERF_EN
        perf_save = perf_cycles;
`endif
        fill_const(1, 1);
        run_job(3, 1'b0, 6, lat);
        chk("abort_no_done_lat", lat, -1);
        chk("abort_done_count", count_log(0, 59), 0);
        chk("abort_pre_busy", busy_log[6], 1);
        chk("abort_busy", busy_log[7], 0);
        chk("abort_en", en_log[7], 0);
        chk("abort_rd_en", rd_log[7], 0);
        chk("abort_a_west", aw_log[7], 0);
        chk("abort_b_north", bn_log[7], 0);
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("abort_perf_held", perf_cycles, perf_save);
`endif

        // reset in the middle of FEED for a K=8 job
        fill_const(1, 1);
        k_len = 8'd8;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_feed_rd_en", buf_rd_en, 1);
        chk("mid_feed_lane0", 32'(lane(a_west, 0)), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",    busy,      0);
        chk("mid_rst_en",      arr_en,    0);
        chk("mid_rst_rd_en",   buf_rd_en, 0);
        chk("mid_rst_a_west",  a_west,    0);
        chk("mid_rst_b_north", b_north,   0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job(1, 1'b0, 0, lat);
        chk("post_rst_latency", lat, 10);
        set_exp_const(1);
        check_grid("post_rst");
        @(negedge clk);

        // skew: K=2, A lane i carries i+1, lane 3 visible only at F+4 and F+5
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < N; i++) begin
                amem[k][i] = 8'(i + 1);
                bmem[k][i] = 8'($urandom_range(0, 255));
            end
        run_job(2, 1'b0, 0, lat);
        chk("skew_latency", lat, 11);
        for (int n = 1; n <= 11; n++) begin
            logic [N*DW-1:0] v;
            v = aw_log[n];
            chk($sformatf("skew_lane3_n%0d", n), 32'(lane(v, 3)),
                (n == 6 || n == 7) ? 32'd4 : 32'd0);
        end
        compute_ref(2);
        check_grid("skew");
        @(negedge clk);

        // full random 4x4 product
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < N; i++) begin
                amem[k][i] = 8'($urandom_range(0, 255));
                bmem[k][i] = 8'($urandom_range(0, 255));
            end
        run_job(4, 1'b0, 0, lat);
        chk("rand_latency", lat, 13);
        compute_ref(4);
        check_grid("rand");
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
